// File: rtl/dcache_wt.sv
// Direct-mapped, write-through, write-allocate data cache with one word per line.
// Misses and stores go to backing memory over a req/ack port while the core is stalled.
module dcache_wt #(
    parameter int WIDTH      = 32,
    parameter int ADDR_W     = 32,
    parameter int INDEX_BITS = 3,
    parameter int CNT_W      = 16
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [ADDR_W-1:0] address,
    input  logic [WIDTH-1:0]  data_in,
    input  logic              read,
    input  logic              write,
    input  logic              flush,
    output logic [WIDTH-1:0]  data_out,
    output logic              stall,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [WIDTH-1:0]  mem_wdata,
    input  logic              mem_ack,
    input  logic [WIDTH-1:0]  mem_rdata,
    output logic [CNT_W-1:0]  hit_cnt,
    output logic [CNT_W-1:0]  miss_cnt
);
    localparam int LINES = 1 << INDEX_BITS;
    localparam int TAG_W = ADDR_W - INDEX_BITS - 2;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        WTHRU,
        DONE
    } state_t;

    state_t             state_q, state_d;
    logic [LINES-1:0]   valid_q, valid_d;
    logic [TAG_W-1:0]   tag_q  [LINES];
    logic [TAG_W-1:0]   tag_d  [LINES];
    logic [WIDTH-1:0]   data_q [LINES];
    logic [WIDTH-1:0]   data_d [LINES];
    logic [ADDR_W-3:0]  addr_q, addr_d;
    logic [WIDTH-1:0]   wdata_q, wdata_d;
    logic [CNT_W-1:0]   hit_cnt_q, hit_cnt_d;
    logic [CNT_W-1:0]   miss_cnt_q, miss_cnt_d;

    logic [INDEX_BITS-1:0] req_index, lat_index, rd_index;
    logic [TAG_W-1:0]      req_tag, lat_tag;
    logic                  req_hit;
    logic                  unused_byte_offset;

    assign req_index          = address[INDEX_BITS+1:2];
    assign req_tag            = address[ADDR_W-1:INDEX_BITS+2];
    assign lat_index          = addr_q[INDEX_BITS-1:0];
    assign lat_tag            = addr_q[ADDR_W-3:INDEX_BITS];
    assign req_hit            = valid_q[req_index] && (tag_q[req_index] == req_tag);
    assign unused_byte_offset = ^address[1:0];

    // Outside IDLE the visible line is the latched one, so the installed word shows in DONE.
    assign data_out  = data_q[rd_index];
    assign mem_addr  = {addr_q, 2'b00};
    assign mem_wdata = wdata_q;
    assign hit_cnt   = hit_cnt_q;
    assign miss_cnt  = miss_cnt_q;

    always_comb begin
        state_d    = state_q;
        valid_d    = valid_q;
        tag_d      = tag_q;
        data_d     = data_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        rd_index   = lat_index;
        stall      = 1'b0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        case (state_q)
            IDLE: begin
                rd_index = req_index;
                if (write) begin
                    stall      = 1'b1;
                    addr_d     = address[ADDR_W-1:2];
                    wdata_d    = data_in;
                    miss_cnt_d = miss_cnt_q + 1'b1;
                    state_d    = WTHRU;
                end else if (read) begin
                    if (req_hit) begin
                        hit_cnt_d = hit_cnt_q + 1'b1;
                    end else begin
                        stall      = 1'b1;
                        addr_d     = address[ADDR_W-1:2];
                        miss_cnt_d = miss_cnt_q + 1'b1;
                        state_d    = FILL;
                    end
                end else if (flush) begin
                    valid_d = '0;
                end
            end
            FILL: begin
                stall   = 1'b1;
                mem_req = 1'b1;
                if (mem_ack) begin
                    data_d[lat_index]  = mem_rdata;
                    tag_d[lat_index]   = lat_tag;
                    valid_d[lat_index] = 1'b1;
                    state_d            = DONE;
                end
            end
            WTHRU: begin
                stall   = 1'b1;
                mem_req = 1'b1;
                mem_we  = 1'b1;
                if (mem_ack) begin
                    data_d[lat_index]  = wdata_q;
                    tag_d[lat_index]   = lat_tag;
                    valid_d[lat_index] = 1'b1;
                    state_d            = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= IDLE;
            valid_q    <= '0;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            valid_q    <= valid_d;
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    // Payload storage carries no reset; a stray write on a reset edge is hidden by the cleared valid bits.
    always_ff @(posedge CLK) begin
        tag_q   <= tag_d;
        data_q  <= data_d;
        addr_q  <= addr_d;
        wdata_q <= wdata_d;
    end
endmodule

// File: tb/tb_dcache_wt.sv
// Randomised scoreboard bench for dcache_wt: the driver predicts responses from a
// line-ownership model, a monitor and a memory responder compare what the DUT presents.
module tb_dcache_wt;
    localparam int WIDTH      = 32;
    localparam int ADDR_W     = 32;
    localparam int INDEX_BITS = 3;
    localparam int CNT_W      = 4;
    localparam int LINES      = 1 << INDEX_BITS;

    logic              clk = 1'b0;
    logic              rst;
    logic [ADDR_W-1:0] address;
    logic [WIDTH-1:0]  data_in;
    logic              read, write, flush;
    logic [WIDTH-1:0]  data_out;
    logic              stall, mem_req, mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [WIDTH-1:0]  mem_wdata;
    logic              mem_ack;
    logic [WIDTH-1:0]  mem_rdata;
    logic [CNT_W-1:0]  hit_cnt, miss_cnt;

    dcache_wt #(
        .WIDTH(WIDTH), .ADDR_W(ADDR_W), .INDEX_BITS(INDEX_BITS), .CNT_W(CNT_W)
    ) dut (
        .CLK(clk), .RST(rst), .address(address), .data_in(data_in),
        .read(read), .write(write), .flush(flush), .data_out(data_out),
        .stall(stall), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit               is_hit;
        logic [WIDTH-1:0] data;
        int               stall_len;
        logic [CNT_W-1:0] hc;
        logic [CNT_W-1:0] mc;
    } resp_t;

    typedef struct {
        bit                we;
        logic [ADDR_W-1:0] addr;
        logic [WIDTH-1:0]  wdata;
    } mtx_t;

    resp_t resp_q[$];
    mtx_t  mtx_q[$];
    int    delay_q[$];
    int    checks = 0;
    int    errors = 0;

    // Reference view: memory contents plus which word address each line currently owns.
    logic [WIDTH-1:0] ref_mem  [64];
    logic [WIDTH-1:0] phys_mem [64];
    bit               line_ok  [LINES];
    int               line_word[LINES];
    int               n_hits, n_misses;

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < LINES; i++) line_ok[i] = 0;
        n_hits   = 0;
        n_misses = 0;
    endtask

    task automatic apply_stimulus(input bit rd, input bit wr, input bit fl,
                                  input logic [ADDR_W-1:0] addr, input logic [WIDTH-1:0] din,
                                  input int delay);
        int    w;
        int    idx;
        bit    goes_to_mem;
        resp_t r;
        w           = int'(addr[7:2]);
        idx         = w % LINES;
        goes_to_mem = 0;
        @(posedge clk);
        #1;
        if (wr) begin
            n_misses++;
            ref_mem[w]     = din;
            line_ok[idx]   = 1;
            line_word[idx] = w;
            r = '{0, din, delay + 2, CNT_W'(n_hits), CNT_W'(n_misses)};
            resp_q.push_back(r);
            mtx_q.push_back('{1'b1, {addr[ADDR_W-1:2], 2'b00}, din});
            delay_q.push_back(delay);
            goes_to_mem = 1;
        end else if (rd) begin
            if (line_ok[idx] && line_word[idx] == w) begin
                r = '{1, ref_mem[w], 0, CNT_W'(n_hits), CNT_W'(n_misses)};
                n_hits++;
            end else begin
                n_misses++;
                line_ok[idx]   = 1;
                line_word[idx] = w;
                r = '{0, ref_mem[w], delay + 2, CNT_W'(n_hits), CNT_W'(n_misses)};
                mtx_q.push_back('{1'b0, {addr[ADDR_W-1:2], 2'b00}, '0});
                delay_q.push_back(delay);
                goes_to_mem = 1;
            end
            resp_q.push_back(r);
        end else if (fl) begin
            for (int i = 0; i < LINES; i++) line_ok[i] = 0;
        end
        address = addr;
        data_in = din;
        read    = rd;
        write   = wr;
        flush   = fl;
        @(posedge clk);
        #1;
        read    = 0;
        write   = 0;
        flush   = 0;
        data_in = $urandom;
        if (goes_to_mem) begin
            int n;
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (stall && n < 200);
            if (stall) begin
                checks++;
                errors++;
                $display("[TB] FAIL completion_timeout: stall still %0b after %0d cycles", stall, n);
            end
        end
    endtask

    task automatic monitor_event(input bit observed_hit, input int run);
        resp_t r;
        if (resp_q.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_completion: got hit=%0b with no expected response", observed_hit);
        end else begin
            r = resp_q.pop_front();
            check_output("hit_path", observed_hit, r.is_hit);
            check_output("data_out", data_out, r.data);
            if (!observed_hit) check_output("stall_cycles", run, r.stall_len);
            check_output("hit_cnt", hit_cnt, r.hc);
            check_output("miss_cnt", miss_cnt, r.mc);
        end
    endtask

    // Monitor: a request cycle without stall is a hit; stall falling marks the DONE cycle.
    initial begin
        int run;
        bit prev;
        run  = 0;
        prev = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                run  = 0;
                prev = 0;
            end else begin
                if ((read || write) && !stall) monitor_event(1, 0);
                if (stall) begin
                    run++;
                end else if (prev) begin
                    monitor_event(0, run);
                    run = 0;
                end
                prev = stall;
            end
        end
    end

    // Backing memory: checks each request, then acks after the planned delay.
    initial begin
        mtx_t             m;
        int               d;
        bit               cap_we;
        logic [ADDR_W-1:0] cap_addr;
        logic [WIDTH-1:0] cap_wdata;
        mem_ack   = 0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (mem_req && !rst) begin
                cap_we    = mem_we;
                cap_addr  = mem_addr;
                cap_wdata = mem_wdata;
                if (mtx_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_mem_req: got addr %0h with none expected", cap_addr);
                end else begin
                    m = mtx_q.pop_front();
                    check_output("mem_we", cap_we, m.we);
                    check_output("mem_addr", cap_addr, m.addr);
                    if (m.we) check_output("mem_wdata", cap_wdata, m.wdata);
                end
                d = (delay_q.size() > 0) ? delay_q.pop_front() : 0;
                repeat (d) @(negedge clk);
                if (cap_we) begin
                    phys_mem[cap_addr[7:2]] = cap_wdata;
                    mem_rdata = $urandom;
                end else begin
                    mem_rdata = phys_mem[cap_addr[7:2]];
                end
                mem_ack = 1;
                @(negedge clk);
                mem_ack   = 0;
                mem_rdata = $urandom;
            end
        end
    end

    initial begin
        #1_000_000;
        checks++;
        errors++;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        logic [ADDR_W-1:0] a;
        int                sel;
        rst     = 1;
        address = '0;
        data_in = '0;
        read    = 0;
        write   = 0;
        flush   = 0;
        for (int i = 0; i < 64; i++) begin
            ref_mem[i]  = 32'(i) * 32'h9E37_79B1 + 32'h1357_2468;
            phys_mem[i] = ref_mem[i];
        end
        ref_mem[1]  = 32'hDEAD_BEEF;
        phys_mem[1] = 32'hDEAD_BEEF;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 0;
        check_output("reset_stall", stall, 0);
        check_output("reset_mem_req", mem_req, 0);
        check_output("reset_mem_we", mem_we, 0);
        check_output("reset_hit_cnt", hit_cnt, 0);
        check_output("reset_miss_cnt", miss_cnt, 0);

        apply_stimulus(1, 0, 0, 32'h0000_0004, 32'h0, 3);
        apply_stimulus(1, 0, 0, 32'h0000_0004, 32'h0, 0);
        check_output("hit_cnt_after_first_hit", hit_cnt, 1);
        apply_stimulus(0, 1, 0, 32'h0000_0008, 32'h1234_5678, 2);
        apply_stimulus(1, 0, 0, 32'h0000_0008, 32'h0, 0);
        apply_stimulus(1, 0, 0, 32'h0000_0024, 32'h0, 1);
        apply_stimulus(1, 0, 0, 32'h0000_0004, 32'h0, 0);
        apply_stimulus(1, 1, 0, 32'h0000_000C, 32'hA5A5_A5A5, 1);
        apply_stimulus(1, 0, 0, 32'h0000_0010, 32'h0, 0);
        apply_stimulus(1, 0, 0, 32'h0000_0014, 32'h0, 2);
        apply_stimulus(1, 0, 0, 32'h0000_0018, 32'h0, 1);
        apply_stimulus(0, 0, 1, 32'h0000_0000, 32'h0, 0);
        apply_stimulus(1, 0, 0, 32'h0000_0010, 32'h0, 0);
        apply_stimulus(1, 0, 0, 32'h0000_0014, 32'h0, 0);
        apply_stimulus(1, 0, 0, 32'h0000_0018, 32'h0, 0);

        // Reset two cycles into a fill; the responder's late ack must be ignored.
        @(posedge clk);
        #1;
        address = 32'h0000_0030;
        read    = 1;
        mtx_q.push_back('{1'b0, 32'h0000_0030, '0});
        delay_q.push_back(6);
        @(posedge clk);
        #1;
        read = 0;
        @(posedge clk);
        #1;
        rst = 1;
        @(posedge clk);
        #1;
        rst = 0;
        model_reset();
        check_output("mem_req_after_abort", mem_req, 0);
        check_output("stall_after_abort", stall, 0);
        check_output("miss_cnt_after_abort", miss_cnt, 0);
        repeat (10) @(posedge clk);
        apply_stimulus(1, 0, 0, 32'h0000_0030, 32'h0, 1);

        for (int k = 0; k < 300; k++) begin
            sel = $urandom_range(0, 9);
            a   = {25'd0, 5'($urandom_range(0, 31)), 2'($urandom_range(0, 3))};
            if (sel == 0)
                apply_stimulus(0, 0, 1, a, $urandom, 0);
            else
                apply_stimulus(sel <= 6 || sel == 9, sel >= 7, $urandom_range(0, 3) == 0,
                               a, $urandom, $urandom_range(0, 4));
        end

        repeat (10) @(posedge clk);
        check_output("resp_queue_drained", resp_q.size(), 0);
        check_output("mem_queue_drained", mtx_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
